// File: rtl/text_console.sv
// Character-stream front end for the text-mode VGA block.
// Accepts one byte per handshake, tracks a logical cursor and emits
// registered cell writes, hardware scroll with bottom-row clear, and
// full-screen clear.
module text_console #(
    parameter int unsigned COLS       = 160,
    parameter int unsigned ROWS       = 45,
    parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic [11:0] fg_color,
    input  logic [11:0] bg_color,
    output logic [7:0]  write_posx,
    output logic [5:0]  write_posy,
    output logic [31:0] write_value,
    output logic        write_enable,
    output logic [5:0]  v_offset
);

    typedef enum logic [1:0] {
        ST_CLEAR_ALL,
        ST_IDLE,
        ST_CLEAR_ROW
    } state_t;

    localparam logic [7:0] COL_LAST = 8'(COLS - 1);
    localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);
    localparam logic [6:0] ROWS_W7  = 7'(ROWS);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    state_t      state_q, state_d;
    logic [7:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [5:0]  voff_q, voff_d;
    logic [7:0]  cx_q, cx_d;
    logic [5:0]  cy_q, cy_d;
    logic [11:0] fg_q, fg_d;
    logic [11:0] bg_q, bg_d;
    logic        we_q, we_d;
    logic [7:0]  px_q, px_d;
    logic [5:0]  py_q, py_d;
    logic [31:0] val_q, val_d;

    logic        advance;
    logic [5:0]  phys_cur;
    logic [5:0]  phys_bot;

    // Logical-to-physical row mapping: 7-bit sum, then one conditional subtract.
    function automatic logic [5:0] phys(input logic [5:0] r, input logic [5:0] off);
        logic [6:0] sum;
        sum = {1'b0, r} + {1'b0, off};
        if (sum >= ROWS_W7) begin
            sum = sum - ROWS_W7;
        end
        return sum[5:0];
    endfunction

    assign phys_cur     = phys(row_q, voff_q);
    assign phys_bot     = phys(ROW_LAST, voff_q);

    assign char_ready   = (state_q == ST_IDLE);
    assign write_enable = we_q;
    assign write_posx   = px_q;
    assign write_posy   = py_q;
    assign write_value  = val_q;
    assign v_offset     = voff_q;

    // Next-state, cursor, scroll and cell-write decode.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        voff_d  = voff_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        fg_d    = fg_q;
        bg_d    = bg_q;
        we_d    = 1'b0;
        px_d    = px_q;
        py_d    = py_q;
        val_d   = val_q;
        advance = 1'b0;

        unique case (state_q)
            ST_CLEAR_ALL: begin
                we_d  = 1'b1;
                px_d  = cx_q;
                py_d  = cy_q;
                val_d = {fg_q, bg_q, BLANK_CHAR};
                if (cx_q == COL_LAST) begin
                    cx_d = '0;
                    if (cy_q == ROW_LAST) begin
                        cy_d    = '0;
                        col_d   = '0;
                        row_d   = '0;
                        voff_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cy_d = cy_q + 6'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end

            ST_IDLE: begin
                if (char_valid) begin
                    case (char_data)
                        CH_LF: begin
                            col_d   = '0;
                            advance = 1'b1;
                        end
                        CH_CR: begin
                            col_d = '0;
                        end
                        CH_BS: begin
                            if (col_q != '0) begin
                                col_d = col_q - 8'd1;
                            end
                        end
                        CH_FF: begin
                            cx_d    = '0;
                            cy_d    = '0;
                            fg_d    = fg_color;
                            bg_d    = bg_color;
                            state_d = ST_CLEAR_ALL;
                        end
                        default: begin
                            we_d  = 1'b1;
                            px_d  = col_q;
                            py_d  = phys_cur;
                            val_d = {fg_color, bg_color, char_data};
                            if (col_q == COL_LAST) begin
                                col_d   = '0;
                                advance = 1'b1;
                            end else begin
                                col_d = col_q + 8'd1;
                            end
                        end
                    endcase

                    // The glyph above was already written through the old
                    // offset; the scroll only redirects later writes.
                    if (advance) begin
                        if (row_q < ROW_LAST) begin
                            row_d = row_q + 6'd1;
                        end else begin
                            voff_d  = (voff_q == ROW_LAST) ? 6'd0 : voff_q + 6'd1;
                            fg_d    = fg_color;
                            bg_d    = bg_color;
                            cx_d    = '0;
                            state_d = ST_CLEAR_ROW;
                        end
                    end
                end
            end

            ST_CLEAR_ROW: begin
                we_d  = 1'b1;
                px_d  = cx_q;
                py_d  = phys_bot;
                val_d = {fg_q, bg_q, BLANK_CHAR};
                if (cx_q == COL_LAST) begin
                    cx_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_CLEAR_ALL;
            end
        endcase
    end

    // State register; reset restarts a full clear with freshly sampled colours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR_ALL;
            col_q   <= '0;
            row_q   <= '0;
            voff_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            fg_q    <= fg_color;
            bg_q    <= bg_color;
            we_q    <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            voff_q  <= voff_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            we_q    <= we_d;
            px_q    <= px_d;
            py_q    <= py_d;
            val_q   <= val_d;
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Directed, table-driven bench for text_console: cursor control codes,
// line wrap, scroll with bottom-row clear, offset wrap, reset mid-clear
// and form-feed clear.
module tb_text_console;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic [11:0] fg_color;
    logic [11:0] bg_color;
    logic [7:0]  write_posx;
    logic [5:0]  write_posy;
    logic [31:0] write_value;
    logic        write_enable;
    logic [5:0]  v_offset;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    text_console #(.COLS(160), .ROWS(45), .BLANK_CHAR(8'h20)) dut (
        .clk          (clk),
        .rst          (rst),
        .char_data    (char_data),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .fg_color     (fg_color),
        .bg_color     (bg_color),
        .write_posx   (write_posx),
        .write_posy   (write_posy),
        .write_value  (write_value),
        .write_enable (write_enable),
        .v_offset     (v_offset)
    );

    typedef struct {
        logic [7:0]  ch;
        logic [11:0] fg;
        logic [11:0] bg;
        logic        we;
        logic [7:0]  x;
        logic [5:0]  y;
        logic [31:0] val;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called at a negedge; waits (bounded) for ready, presents one byte for
    // one cycle and samples the outputs at the negedge after acceptance.
    task automatic send_char(input logic [7:0] c, input logic [11:0] f, input logic [11:0] b,
                             output logic we, output logic [7:0] x, output logic [5:0] y,
                             output logic [31:0] v);
        int unsigned n = 0;
        while (char_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, char_ready}, 32'd1);
        char_data  = c;
        fg_color   = f;
        bg_color   = b;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        we = write_enable;
        x  = write_posx;
        y  = write_posy;
        v  = write_value;
    endtask

    // Expects 7200 consecutive blank writes in raster order, then IDLE.
    task automatic check_clear_all(input logic [31:0] req_val);
        int unsigned ex = 0, ey = 0, cnt = 0, bad = 0, n = 0;
        while (cnt < 7200 && n < 7400) begin
            @(negedge clk);
            n++;
            if (write_enable !== 1'b1) begin
                bad++;
            end else begin
                if (write_posx !== 8'(ex) || write_posy !== 6'(ey) || write_value !== req_val)
                    bad++;
                cnt++;
                if (cnt < 7200 && char_ready !== 1'b0) bad++;
                if (ex == 159) begin
                    ex = 0;
                    ey++;
                end else begin
                    ex++;
                end
            end
        end
        check("clear_all_count", cnt, 32'd7200);
        check("clear_all_cells", bad, 32'd0);
        @(negedge clk);
        check("clear_all_done_we", {31'd0, write_enable}, 32'd0);
        check("clear_all_done_ready", {31'd0, char_ready}, 32'd1);
        check("clear_all_done_voff", {26'd0, v_offset}, 32'd0);
    endtask

    // Expects the 160 bottom-row blank writes following a scroll accept.
    task automatic check_clear_row(input logic [5:0] req_y, input logic [31:0] req_val);
        int unsigned bad = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (write_enable !== 1'b1 || write_posx !== 8'(i) || write_posy !== req_y ||
                write_value !== req_val || char_ready !== (i == 159))
                bad++;
        end
        check("clear_row_cells", bad, 32'd0);
    endtask

    logic        o_we;
    logic [7:0]  o_x;
    logic [5:0]  o_y;
    logic [31:0] o_val;
    int unsigned bad;

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'h41, 12'hF00, 12'h00F, 1'b1, 8'd0, 6'd0, 32'hF0000F41};
        vecs[1]  = '{8'h42, 12'hF00, 12'h00F, 1'b1, 8'd1, 6'd0, 32'hF0000F42};
        vecs[2]  = '{8'h0D, 12'h000, 12'h000, 1'b0, 8'd1, 6'd0, 32'hF0000F42};
        vecs[3]  = '{8'h43, 12'h0F0, 12'h000, 1'b1, 8'd0, 6'd0, 32'h0F000043};
        vecs[4]  = '{8'h08, 12'h000, 12'h000, 1'b0, 8'd0, 6'd0, 32'h0F000043};
        vecs[5]  = '{8'h08, 12'h000, 12'h000, 1'b0, 8'd0, 6'd0, 32'h0F000043};
        vecs[6]  = '{8'h44, 12'h123, 12'h456, 1'b1, 8'd0, 6'd0, 32'h12345644};
        vecs[7]  = '{8'h0A, 12'h000, 12'h000, 1'b0, 8'd0, 6'd0, 32'h12345644};
        vecs[8]  = '{8'h45, 12'h0F0, 12'h0F0, 1'b1, 8'd0, 6'd1, 32'h0F00F045};
        vecs[9]  = '{8'h46, 12'hABC, 12'hDEF, 1'b1, 8'd1, 6'd1, 32'hABCDEF46};
        vecs[10] = '{8'h0D, 12'h000, 12'h000, 1'b0, 8'd1, 6'd1, 32'hABCDEF46};
        vecs[11] = '{8'h0A, 12'h000, 12'h000, 1'b0, 8'd1, 6'd1, 32'hABCDEF46};

        rst        = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        fg_color   = 12'hFFF;
        bg_color   = 12'h000;
        @(negedge clk);
        @(negedge clk);
        check("reset_we",    {31'd0, write_enable}, 32'd0);
        check("reset_posx",  {24'd0, write_posx}, 32'd0);
        check("reset_posy",  {26'd0, write_posy}, 32'd0);
        check("reset_value", write_value, 32'd0);
        check("reset_voff",  {26'd0, v_offset}, 32'd0);
        check("reset_ready", {31'd0, char_ready}, 32'd0);
        rst = 1'b0;
        check_clear_all(32'hFFF00020);

        // Control codes and single-cell writes; cursor ends at (0,2).
        for (int i = 0; i < 12; i++) begin
            send_char(vecs[i].ch, vecs[i].fg, vecs[i].bg, o_we, o_x, o_y, o_val);
            check($sformatf("vec%0d_we", i),   {31'd0, o_we}, {31'd0, vecs[i].we});
            check($sformatf("vec%0d_posx", i), {24'd0, o_x},  {24'd0, vecs[i].x});
            check($sformatf("vec%0d_posy", i), {26'd0, o_y},  {26'd0, vecs[i].y});
            check($sformatf("vec%0d_val", i),  o_val,         vecs[i].val);
        end

        // A full row of 'x' then wrap onto the next row.
        bad = 0;
        for (int i = 0; i < 160; i++) begin
            send_char(8'h78, 12'h0F0, 12'h000, o_we, o_x, o_y, o_val);
            if (o_we !== 1'b1 || o_x !== 8'(i) || o_y !== 6'd2 || o_val !== 32'h0F000078) bad++;
        end
        check("row_fill_cells", bad, 32'd0);
        check("row_fill_last_x", {24'd0, o_x}, 32'd159);
        send_char(8'h79, 12'h0F0, 12'h000, o_we, o_x, o_y, o_val);
        check("wrap_posx", {24'd0, o_x}, 32'd0);
        check("wrap_posy", {26'd0, o_y}, 32'd3);
        send_char(8'h0D, 12'h000, 12'h000, o_we, o_x, o_y, o_val);
        check("cr_no_write", {31'd0, o_we}, 32'd0);
        send_char(8'h08, 12'h000, 12'h000, o_we, o_x, o_y, o_val);
        check("bs_col0_no_write", {31'd0, o_we}, 32'd0);
        send_char(8'h7A, 12'h0F0, 12'h000, o_we, o_x, o_y, o_val);
        check("bs_col0_posx", {24'd0, o_x}, 32'd0);
        check("bs_col0_posy", {26'd0, o_y}, 32'd3);

        // Walk down to the bottom row.
        bad = 0;
        for (int i = 0; i < 41; i++) begin
            send_char(8'h0A, 12'h000, 12'h000, o_we, o_x, o_y, o_val);
            if (o_we !== 1'b0) bad++;
        end
        check("lf_walk_no_write", bad, 32'd0);
        send_char(8'h70, 12'hFFF, 12'h000, o_we, o_x, o_y, o_val);
        check("bottom_posx", {24'd0, o_x}, 32'd0);
        check("bottom_posy", {26'd0, o_y}, 32'd44);
        check("bottom_val", o_val, 32'hFFF00070);

        // First scroll: offset 0 -> 1, bottom row is physical 0.
        send_char(8'h0A, 12'h5A5, 12'h0A0, o_we, o_x, o_y, o_val);
        check("scroll1_no_write", {31'd0, o_we}, 32'd0);
        check("scroll1_voff", {26'd0, v_offset}, 32'd1);
        check("scroll1_ready", {31'd0, char_ready}, 32'd0);
        check_clear_row(6'd0, 32'h5A50A020);
        send_char(8'h71, 12'hF00, 12'h00F, o_we, o_x, o_y, o_val);
        check("after_scroll1_posx", {24'd0, o_x}, 32'd0);
        check("after_scroll1_posy", {26'd0, o_y}, 32'd0);
        check("after_scroll1_val", o_val, 32'hF0000F71);

        // Scroll repeatedly up to offset 44.
        bad = 0;
        for (int k = 2; k <= 44; k++) begin
            send_char(8'h0A, 12'h000, 12'h000, o_we, o_x, o_y, o_val);
            if (v_offset !== 6'(k)) bad++;
        end
        check("scroll_walk_voff", bad, 32'd0);

        // Wrap-triggered scroll at offset 44: glyph on physical 43, offset wraps to 0.
        bad = 0;
        for (int i = 0; i < 159; i++) begin
            send_char(8'h77, 12'h111, 12'h222, o_we, o_x, o_y, o_val);
            if (o_we !== 1'b1 || o_x !== 8'(i) || o_y !== 6'd43) bad++;
        end
        check("off44_row_cells", bad, 32'd0);
        send_char(8'h77, 12'h111, 12'h222, o_we, o_x, o_y, o_val);
        check("off44_last_we",   {31'd0, o_we}, 32'd1);
        check("off44_last_posx", {24'd0, o_x}, 32'd159);
        check("off44_last_posy", {26'd0, o_y}, 32'd43);
        check("off44_last_val",  o_val, 32'h11122277);
        check("off_wrap_voff",   {26'd0, v_offset}, 32'd0);
        check("off_wrap_ready",  {31'd0, char_ready}, 32'd0);
        check_clear_row(6'd44, 32'h11122220);
        send_char(8'h72, 12'h00F, 12'hF00, o_we, o_x, o_y, o_val);
        check("after_wrap_posx", {24'd0, o_x}, 32'd0);
        check("after_wrap_posy", {26'd0, o_y}, 32'd44);
        check("after_wrap_val",  o_val, 32'h00FF0072);

        // Reset in the middle of a bottom-row clear.
        send_char(8'h0A, 12'h777, 12'h888, o_we, o_x, o_y, o_val);
        check("pre_rst_voff", {26'd0, v_offset}, 32'd1);
        for (int i = 0; i < 80; i++) @(negedge clk);
        rst      = 1'b1;
        fg_color = 12'hFFF;
        bg_color = 12'h000;
        @(negedge clk);
        check("midrst_we",    {31'd0, write_enable}, 32'd0);
        check("midrst_posx",  {24'd0, write_posx}, 32'd0);
        check("midrst_posy",  {26'd0, write_posy}, 32'd0);
        check("midrst_value", write_value, 32'd0);
        check("midrst_voff",  {26'd0, v_offset}, 32'd0);
        check("midrst_ready", {31'd0, char_ready}, 32'd0);
        rst = 1'b0;
        check_clear_all(32'hFFF00020);

        // Form feed after a scroll resets offset and cursor.
        for (int i = 0; i < 44; i++) send_char(8'h0A, 12'h000, 12'h000, o_we, o_x, o_y, o_val);
        send_char(8'h0A, 12'h000, 12'h000, o_we, o_x, o_y, o_val);
        check("pre_ff_voff", {26'd0, v_offset}, 32'd1);
        send_char(8'h0C, 12'h0F0, 12'h00F, o_we, o_x, o_y, o_val);
        check("ff_no_write", {31'd0, o_we}, 32'd0);
        check("ff_ready",    {31'd0, char_ready}, 32'd0);
        check_clear_all(32'h0F000F20);
        send_char(8'h5A, 12'h246, 12'h8AC, o_we, o_x, o_y, o_val);
        check("after_ff_posx", {24'd0, o_x}, 32'd0);
        check("after_ff_posy", {26'd0, o_y}, 32'd0);
        check("after_ff_val",  o_val, 32'h2468AC5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_console.md
Name: text_console

Overview:
- Character-stream front end for the text-mode VGA block. Consumes one byte per handshake and maintains a cursor.
- Emits cell writes on that block's write port: `write_posx`/`write_posy`/`write_value`/`write_enable`, in the write clock domain. Drives its scroll input `v_offset`.
- Handles newline, carriage return, backspace, line wrap, hardware scroll with bottom-row clear, and full-screen clear.

Parameters:
- COLS, 160, text columns (1280/8).
- ROWS, 45, text rows (720/16).
- BLANK_CHAR, 8'h20, glyph code used when clearing cells.

Ports:
- clk  in  1  write-domain clock; also drives the display block's write_clk.
- rst  in  1  synchronous, active-high reset.
- char_data  in  8  incoming character code.
- char_valid  in  1  char_data valid.
- char_ready  out  1  block can accept a character this cycle.
- fg_color  in  12  foreground RGB444, sampled on accept and at clear start.
- bg_color  in  12  background RGB444, sampled on accept and at clear start.
- write_posx  out  8  cell column, 0..COLS-1.
- write_posy  out  6  physical cell row, 0..ROWS-1.
- write_value  out  32  {fg[11:0], bg[11:0], glyph[7:0]}.
- write_enable  out  1  cell write strobe, one cell per cycle.
- v_offset  out  6  physical row index of logical row 0, 0..ROWS-1.

Behaviour:
- Clock/reset: one clock `clk`; reset is synchronous, active-high. All state updates on posedge clk.
- Reset values:
  - write_enable=0, write_posx=0, write_posy=0, write_value=0, v_offset=0, char_ready=0.
  - Cursor (col,row)=(0,0).
  - State goes to CLEAR_ALL.
  - A reset during any state, including mid-clear, restarts from this point.
- Handshake: a character is accepted on a cycle where char_valid&&char_ready. char_ready=1 only in IDLE, and is driven combinationally from state.
- Cursor model:
  - row is logical, 0 = top of screen.
  - Physical row phys(r) = r+v_offset, minus ROWS if the sum is >= ROWS. No divider.
- Write outputs are registered. A cell write appears 1 cycle after acceptance, with write_enable high for exactly that cycle.
- States:
  - CLEAR_ALL:
    - Latch fg/bg on entry.
    - Emit COLS*ROWS=7200 writes, one per cycle, posx 0..COLS-1 inner loop, posy 0..ROWS-1 outer loop (physical rows). value={fg,bg,BLANK_CHAR}.
    - On the last write: cursor=(0,0), v_offset=0, go to IDLE.
  - IDLE, on accept, decoded by char_data:
    - 8'h0A (LF): col=0; advance line. No write.
    - 8'h0D (CR): col=0. No write.
    - 8'h08 (BS): col=col-1 if col>0, else unchanged. No write. Does not move to the previous row.
    - 8'h0C (FF): go to CLEAR_ALL. No write.
    - Any other code: write {fg,bg,char_data} at (col, phys(row)). Then col+1; if col was COLS-1, col=0 and advance line.
  - Advance line:
    - If row<ROWS-1: row+1, stay in IDLE.
    - Else (row stays ROWS-1): v_offset=(v_offset+1) wrap ROWS→0, latch fg/bg, go to CLEAR_ROW.
  - CLEAR_ROW:
    - Emit COLS writes at posy = phys(ROWS-1) using the new v_offset (= old v_offset). posx 0..COLS-1, value={fg,bg,BLANK_CHAR}.
    - Then return to IDLE. char_ready=0 throughout.
- v_offset changes only at scroll start or CLEAR_ALL end. It is held stable for at least COLS cycles, which the display's stability resynchroniser requires.
- The single-cycle glyph write and the scroll decision happen on the same accept. The printed cell lands on the old bottom row before the offset changes.
- write_posx/write_posy hold their last value when write_enable=0.
- Width rules:
  - Counters are 8-bit for col and 6-bit for row.
  - The phys sum is computed at 7 bits before the conditional subtract.
  - The CLEAR_ALL cell counter is separate row/col counters, not a flat 13-bit count.

Test Plan:
- Reset, char_valid=0, fg=12'hFFF, bg=12'h000: exactly 7200 write_enable pulses covering all (x,y), value 32'hFFF00020. char_ready rises the cycle after the last write; v_offset=0.
- After init, send 'A'(8'h41), fg=12'hF00, bg=12'h00F: one write at (0,0) value 32'hF0000F41 one cycle after accept. Next 'B' goes to (1,0).
- Send 160 'x' from (0,0): last write at (159,0). The next 'y' writes at (0,1). Then CR, BS at col 0: no write, cursor stays (0,1).
- Fill to row 44, send LF: v_offset 0→1, char_ready low 160 cycles, 160 blank writes at posy=0. The next char writes at posy=0 (phys(44) with offset 1).
- At v_offset=44, trigger a scroll: v_offset wraps to 0, clear writes at posy=44. After that, row 44 maps to phys 44 and row 0 to phys 0.
- Assert rst mid CLEAR_ROW (cycle 80): outputs return to reset values next cycle, and a full 7200-write CLEAR_ALL restarts. Send 8'h0C in IDLE: CLEAR_ALL runs, cursor ends at (0,0), v_offset=0.
